// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI transmit scheduler.
package spi_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_LOW,
    WAIT_HIGH,
    GAP
  } spi_sched_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last grant
// and wraps, so the most recently served requester has the lowest priority.
module rr_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_grant_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      gnt_idx_o,
  output logic               any_gnt_o
);

  // Cyclic first-valid search from last_grant+1.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_i) + k) % NUM_REQ;
      if (en_i && !any_gnt_o && req_i[IW'(idx)]) begin
        any_gnt_o         = 1'b1;
        gnt_idx_o         = IW'(idx);
        gnt_o[IW'(idx)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Round-robin scheduler sharing one SPI serializer among NUM_REQ requesters.
// Build option SPI_TX_TIMEOUT_EN adds a frame watchdog driving err_timeout.
module spi_tx_scheduler
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          send_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ser_trigger,
  output logic [DATA_WIDTH-1:0]         ser_msg,
  input  logic                          ser_sel,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(NUM_REQ)-1:0]    done_id,
  output logic                          err_timeout
);

  localparam int IW       = idx_w(NUM_REQ);
  localparam int GW       = idx_w(GAP_CYCLES + 1);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  spi_sched_state_t state_q, state_d;
  logic [IW-1:0]         last_grant_q, last_grant_d;
  logic [IW-1:0]         cur_id_q, cur_id_d;
  logic [DATA_WIDTH-1:0] ser_msg_q, ser_msg_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_bytes;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               any_gnt;

  assign req_bytes = req_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .en_i         (send_en && (state_q == IDLE)),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx),
    .any_gnt_o    (any_gnt)
  );

`ifdef SPI_TX_TIMEOUT_EN
  localparam int TW = idx_w(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      cur_id_q     <= '0;
      ser_msg_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      ser_msg_q    <= ser_msg_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    ser_msg_d    = ser_msg_q;
    gap_cnt_d    = gap_cnt_q;
    req_ready    = '0;
    ser_trigger  = 1'b0;
    frame_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_gnt) begin
          req_ready    = gnt;
          ser_msg_d    = req_bytes[gnt_idx];
          cur_id_d     = gnt_idx;
          last_grant_d = gnt_idx;
          state_d      = TRIG;
        end
      end
      TRIG: begin
        ser_trigger = 1'b1;
        state_d     = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!ser_sel) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (ser_sel) begin
          frame_done = 1'b1;
          gap_cnt_d  = '0;
          state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_LAST)) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SPI_TX_TIMEOUT_EN
    // A completed frame wins over an expiry landing in the same cycle.
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    if (state_q == WAIT_LOW || state_q == WAIT_HIGH) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (!frame_done && tmo_cnt_d == TW'(TIMEOUT_CYCLES)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
    if (state_d == TRIG) tmo_cnt_d = '0;
`endif
  end

  assign ser_msg = ser_msg_q;
  assign busy    = (state_q != IDLE);
  assign done_id = frame_done ? cur_id_q : '0;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Scoreboard bench for spi_tx_scheduler with a behavioural serializer model.
module tb_spi_tx_scheduler;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int GAP  = 2;
  localparam int TMO  = 16;
  localparam int FLEN = 4;

  typedef struct {
    int        id;
    logic [7:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          send_en = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic          ser_trigger;
  logic [DW-1:0] ser_msg;
  logic          ser_sel;
  logic          busy;
  logic          frame_done;
  logic [1:0]    done_id;
  logic          err_timeout;

  spi_tx_scheduler #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .nrst(nrst), .send_en(send_en), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .ser_trigger(ser_trigger),
    .ser_msg(ser_msg), .ser_sel(ser_sel), .busy(busy), .frame_done(frame_done),
    .done_id(done_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int n_gnt = 0, n_trig = 0, n_done = 0;
  int t_ready = 0, t_done = 0, t_rise = 0, t_trig = 0;
  bit have_done = 0, gap_chk = 0, stuck = 0;
  logic sel_prev = 1'b1;
  int gcnt [NR];
  exp_t gnt_q[$], trig_q[$], done_q[$];
  exp_t me;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Serializer: drops sel the cycle after the trigger, holds it low FLEN cycles.
  int scnt = 0;
  logic sel_r = 1'b1;
  assign ser_sel = sel_r;
  always @(posedge clk) begin
    if (!nrst) begin
      sel_r <= 1'b1;
      scnt  <= 0;
    end else if (ser_trigger && !stuck) begin
      sel_r <= 1'b0;
      scnt  <= FLEN - 1;
    end else if (!sel_r) begin
      if (scnt == 0) sel_r <= 1'b1;
      else scnt <= scnt - 1;
    end
  end

  // Monitor: pop expectations as the DUT produces grants, triggers and dones.
  always @(negedge clk) begin
    if (nrst) begin
      if (ser_sel && !sel_prev) t_rise = cyc;
      if (req_ready != '0) begin
        if (gnt_q.size() == 0) chk("unexp_gnt", 32'(req_ready), 0);
        else begin
          me = gnt_q.pop_front();
          chk("gnt", 32'(req_ready), 32'd1 << me.id);
          trig_q.push_back(me);
          gcnt[me.id]++;
        end
        if (gap_chk && have_done) chk("gap", cyc - t_done - 1, GAP);
        t_ready = cyc;
        n_gnt++;
      end
      if (ser_trigger) begin
        chk("trig_lat", cyc - t_ready, 1);
        if (trig_q.size() == 0) chk("unexp_trig", 1, 0);
        else begin
          me = trig_q.pop_front();
          chk("msg", 32'(ser_msg), 32'(me.data));
          done_q.push_back(me);
        end
        t_trig = cyc;
        n_trig++;
      end
      if (frame_done) begin
        if (done_q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          me = done_q.pop_front();
          chk("done_id", 32'(done_id), me.id);
          chk("done_t", cyc, t_rise);
        end
        t_done = cyc;
        have_done = 1;
        n_done++;
      end
    end
    sel_prev = ser_sel;
  end

  task automatic wait_gnt(input int n);
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk);
      if (n_gnt >= n) ok = 1;
    end
    if (!ok) chk("wait_gnt", n_gnt, n);
  endtask

  task automatic wait_trig(input int n);
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk);
      if (n_trig >= n) ok = 1;
    end
    if (!ok) chk("wait_trig", n_trig, n);
  endtask

  task automatic wait_done(input int n);
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk);
      if (n_done >= n) ok = 1;
    end
    if (!ok) chk("wait_done", n_done, n);
  endtask

  function automatic exp_t mk(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    return e;
  endfunction

  task automatic check_idle_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_trig"}, ser_trigger, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_rdy"}, 32'(req_ready), 0);
  endtask

  initial begin
    int t_en;
    int te;
    bit seen;
    foreach (gcnt[i]) gcnt[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outs("rst");
    chk("rst_msg", 32'(ser_msg), 0);
    chk("rst_id", 32'(done_id), 0);
    chk("rst_err", err_timeout, 0);
    @(posedge clk); #1 nrst = 1'b1;
    @(negedge clk);
    check_idle_outs("post_rst");

    // Single request, requester 0 first after reset
    gnt_q.push_back(mk(0, 8'hA5));
    @(posedge clk); #1;
    req_data[0 +: 8] = 8'hA5;
    req_valid = 4'b0001;
    send_en = 1'b1;
    wait_gnt(1); #1 req_valid = '0;
    wait_done(1);
    @(negedge clk);
    chk("msg_hold", 32'(ser_msg), 32'hA5);

    // Reset pulse in WAIT_HIGH abandons the frame; next grant is requester 0
    gnt_q.push_back(mk(2, 8'h22));
    @(posedge clk); #1;
    req_data[16 +: 8] = 8'h22;
    req_valid = 4'b0100;
    wait_gnt(2); #1 req_valid = '0;
    wait_trig(2);
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_sel", ser_sel, 0);
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    done_q.delete();
    trig_q.delete();
    have_done = 0;
    foreach (gcnt[i]) gcnt[i] = 0;
    for (int i = 0; i < NR; i++) req_data[i*8 +: 8] = 8'(8'h10 + i);
    gnt_q.push_back(mk(0, 8'h10));
    gnt_q.push_back(mk(1, 8'h11));
    gnt_q.push_back(mk(2, 8'h12));
    gnt_q.push_back(mk(3, 8'h13));
    gnt_q.push_back(mk(0, 8'h10));
    req_valid = 4'b1111;
    gap_chk = 1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_trig", ser_trigger, 0);
    chk("abort_done", frame_done, 0);

    // Fairness with all requesters held valid
    wait_gnt(7); #1 req_valid = '0;
    wait_done(6);
    gap_chk = 0;
    chk("fair0", gcnt[0], 2);
    for (int i = 1; i < NR; i++) chk("fair", gcnt[i], 1);

    // send_en dropped mid-frame
    gnt_q.push_back(mk(1, 8'h33));
    @(posedge clk); #1;
    req_data[8 +: 8] = 8'h33;
    req_valid = 4'b0010;
    wait_gnt(8); #1 req_valid = '0;
    wait_trig(8);
    @(posedge clk); #1;
    send_en = 1'b0;
    req_data[24 +: 8] = 8'h44;
    req_valid = 4'b1000;
    wait_done(7);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("no_gnt_off", 32'(req_ready), 0);
    end
    gnt_q.push_back(mk(3, 8'h44));
    @(posedge clk); #1;
    send_en = 1'b1;
    t_en = cyc;
    wait_gnt(9); #1 req_valid = '0;
    chk("resume_t", t_ready, t_en);
    wait_done(8);

`ifdef SPI_TX_TIMEOUT_EN
    // Serializer never drops sel: watchdog fires and returns to IDLE
    stuck = 1;
    gnt_q.push_back(mk(0, 8'h5A));
    @(posedge clk); #1;
    req_data[0 +: 8] = 8'h5A;
    req_valid = 4'b0001;
    wait_gnt(10); #1 req_valid = '0;
    wait_trig(9);
    seen = 0;
    te = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (err_timeout) begin
        seen = 1;
        te = cyc;
        chk("tmo_busy", busy, 0);
      end
    end
    chk("tmo_seen", seen, 1);
    chk("tmo_lat", te - t_trig, TMO + 1);
    repeat (5) @(negedge clk);
    chk("tmo_sticky", err_timeout, 1);
    chk("tmo_nodone", n_done, 8);
    done_q.delete();
    stuck = 0;
    @(posedge clk); #1 nrst = 1'b0;
    @(posedge clk); #1 nrst = 1'b1;
    @(negedge clk);
    chk("tmo_clr", err_timeout, 0);
`else
    @(negedge clk);
    chk("err_off", err_timeout, 0);
`endif

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

endmodule
